// File: rtl/router_sync_ctrl.sv
`default_nettype none
// ============================================================================
// router_sync_ctrl : address latch, write steering and per-port timeout flush
// Revision 1.0
// ============================================================================
module router_sync_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic [2:0] read_enb,
    input  logic [2:0] empty,
    input  logic [2:0] full,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset,
    output logic       addr_err
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0] r_addr_q;
    logic       r_addr_vld;
    logic [2:0] r_soft_reset;
    logic [2:0] w_write_enb;
    logic       w_fifo_full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr_q   <= 2'b00;
            r_addr_vld <= 1'b0;
        end else if (detect_add) begin
            r_addr_q   <= data_in;
            r_addr_vld <= 1'b1;
        end
    end

    // Steering is driven from the registered address, so a header arriving
    // alongside a write strobe only redirects writes from the next cycle on.
    always_comb begin
        w_write_enb = 3'b000;
        w_fifo_full = 1'b0;
        if (r_addr_vld) begin
            case (r_addr_q)
                2'b00: begin
                    w_write_enb = {2'b00, write_enb_reg};
                    w_fifo_full = full[0];
                end
                2'b01: begin
                    w_write_enb = {1'b0, write_enb_reg, 1'b0};
                    w_fifo_full = full[1];
                end
                2'b10: begin
                    w_write_enb = {write_enb_reg, 2'b00};
                    w_fifo_full = full[2];
                end
                default: begin
                    w_write_enb = 3'b000;
                    w_fifo_full = 1'b0;
                end
            endcase
        end
    end

    assign write_enb = w_write_enb;
    assign fifo_full = w_fifo_full;
    assign addr_err  = r_addr_vld & (r_addr_q == 2'b11);
    assign vld_out   = ~empty;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_port
            logic [CNT_W-1:0] r_cnt;
            logic             w_stall;

            assign w_stall = ~empty[gi] & ~read_enb[gi];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_cnt           <= '0;
                    r_soft_reset[gi] <= 1'b0;
                end else if (!w_stall) begin
                    r_cnt           <= '0;
                    r_soft_reset[gi] <= 1'b0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_cnt           <= '0;
                    r_soft_reset[gi] <= 1'b1;
                end else begin
                    r_cnt           <= r_cnt + 1'b1;
                    r_soft_reset[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign soft_reset = r_soft_reset;

endmodule
`default_nettype wire
